div_ctrl: RTL and testbench



---
 rtl/div_ctrl_if.sv | 22 ++
 rtl/div_ctrl.sv | 148 ++++++++++++++
 tb/tb_div_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// Execute-stage <-> divider request/result bundle.
// master = execute stage, slave = div_ctrl.
interface div_ctrl_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o, busy_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o, busy_o
   );
endinterface

// File: rtl/div_ctrl.sv
// 32-step restoring divider controller for HI/LO; result_o = {remainder, quotient}.
// Define DIV_SIGNED_EN to honour signed_div_i (magnitude conversion + sign fixup).
module div_ctrl (
   input  logic       clk,
   input  logic       rst,
   div_ctrl_if.slave  bus
);

   localparam logic [1:0] DIV_FREE   = 2'b00;
   localparam logic [1:0] DIV_BYZERO = 2'b01;
   localparam logic [1:0] DIV_ON     = 2'b10;
   localparam logic [1:0] DIV_END    = 2'b11;

   logic [1:0]  state;
   logic [4:0]  cnt;
   logic [64:0] dividend;
   logic [31:0] divisor;

   logic [32:0] diff;
   logic        borrow;
   logic [64:0] dividend_step;
   logic [31:0] op1_mag;
   logic [31:0] op2_mag;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;

   // Partial remainder lives in dividend[64:32]; a set bit 64 means it
   // already exceeds any 32-bit divisor, so no borrow is possible.
   always_comb begin
      diff   = {1'b0, dividend[63:32]} - {1'b0, divisor};
      borrow = diff[32] & ~dividend[64];
      if (borrow) begin
         dividend_step = {dividend[63:0], 1'b0};
      end else begin
         dividend_step = {diff[31:0], dividend[31:0], 1'b1};
      end
   end

`ifdef DIV_SIGNED_EN
   logic neg_quot;
   logic neg_rem;

   always_comb begin
      op1_mag  = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1)
                                                          : bus.opdata1_i;
      op2_mag  = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1)
                                                          : bus.opdata2_i;
      quot_fix = neg_quot ? (~dividend_step[31:0] + 32'd1) : dividend_step[31:0];
      rem_fix  = neg_rem  ? (~dividend_step[64:33] + 32'd1) : dividend_step[64:33];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         neg_quot <= 1'b0;
         neg_rem  <= 1'b0;
      end else if (state == DIV_FREE && bus.start_i && !bus.annul_i) begin
         neg_quot <= bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
         neg_rem  <= bus.signed_div_i & bus.opdata1_i[31];
      end
   end
`else
   logic unused_signed_div;

   always_comb begin
      op1_mag           = bus.opdata1_i;
      op2_mag           = bus.opdata2_i;
      quot_fix          = dividend_step[31:0];
      rem_fix           = dividend_step[64:33];
      unused_signed_div = bus.signed_div_i;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= DIV_FREE;
         cnt          <= '0;
         dividend     <= '0;
         divisor      <= '0;
         bus.result_o <= '0;
         bus.ready_o  <= 1'b0;
         bus.busy_o   <= 1'b0;
      end else begin
         case (state)
            DIV_FREE: begin
               bus.result_o <= '0;
               bus.ready_o  <= 1'b0;
               if (bus.start_i && !bus.annul_i) begin
                  bus.busy_o <= 1'b1;
                  if (bus.opdata2_i == 32'd0) begin
                     state <= DIV_BYZERO;
                  end else begin
                     state    <= DIV_ON;
                     cnt      <= '0;
                     dividend <= {32'd0, op1_mag, 1'b0};
                     divisor  <= op2_mag;
                  end
               end
            end

            DIV_BYZERO: begin
               bus.busy_o   <= 1'b0;
               bus.result_o <= '0;
               if (bus.annul_i) begin
                  state <= DIV_FREE;
               end else begin
                  state       <= DIV_END;
                  bus.ready_o <= 1'b1;
               end
            end

            DIV_ON: begin
               // Annul takes priority even over the final step.
               if (bus.annul_i) begin
                  state        <= DIV_FREE;
                  cnt          <= '0;
                  bus.busy_o   <= 1'b0;
                  bus.result_o <= '0;
                  bus.ready_o  <= 1'b0;
               end else begin
                  dividend <= dividend_step;
                  if (cnt == 5'd31) begin
                     state        <= DIV_END;
                     cnt          <= '0;
                     bus.busy_o   <= 1'b0;
                     bus.ready_o  <= 1'b1;
                     bus.result_o <= {rem_fix, quot_fix};
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end

            DIV_END: begin
               if (!bus.start_i) begin
                  state        <= DIV_FREE;
                  bus.ready_o  <= 1'b0;
                  bus.result_o <= '0;
               end
            end

            default: begin
               state <= DIV_FREE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl using immediate assertions.
module tb_div_ctrl;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_fail;

   div_ctrl_if bus ();

   div_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full request: issue, wait (bounded) for ready, check hold, drop start.
   task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
      int   lat;
      logic busy_ok;
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      busy_ok          = 1'b1;
      step();
      lat = 1;
      bus.opdata1_i = $urandom;
      bus.opdata2_i = $urandom;
      while (!bus.ready_o && lat < 100) begin
         if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
         step();
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy during op"}, 64'(busy_ok), 64'd1);
      check({tag, " result"}, bus.result_o, exp_res);
      check({tag, " busy at ready"}, 64'(bus.busy_o), 64'd0);
      step();
      step();
      check({tag, " ready held"}, 64'(bus.ready_o), 64'd1);
      check({tag, " result held"}, bus.result_o, exp_res);
      bus.start_i = 1'b0;
      step();
      check({tag, " ready drop"}, 64'(bus.ready_o), 64'd0);
      check({tag, " result drop"}, bus.result_o, 64'd0);
   endtask

   initial begin
      logic [63:0] exp_neg7_2;
      logic [63:0] exp_min_m1;
      logic        seen_ready;

      n_vec  = 0;
      n_fail = 0;
      rst              = 1'b1;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      step();
      step();
      check("reset result", bus.result_o, 64'd0);
      check("reset ready", 64'(bus.ready_o), 64'd0);
      check("reset busy", 64'(bus.busy_o), 64'd0);
      rst = 1'b0;
      step();

`ifdef DIV_SIGNED_EN
      exp_neg7_2 = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
      exp_min_m1 = {32'h0000_0000, 32'h8000_0000};
`else
      exp_neg7_2 = {32'h0000_0001, 32'h7FFF_FFFC};
      exp_min_m1 = {32'h8000_0000, 32'h0000_0000};
`endif

      do_div("u100/7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
      do_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, exp_neg7_2);
      do_div("u-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, {32'd1, 32'h7FFF_FFFC});
      do_div("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, exp_min_m1);
      do_div("ubig", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 33, {32'h7FFF_FFFE, 32'd1});
      do_div("u5/9", 1'b0, 32'd5, 32'd9, 33, {32'd5, 32'd0});
      do_div("u/1", 1'b0, 32'h1234_5678, 32'd1, 33, {32'd0, 32'h1234_5678});
      do_div("u12/0", 1'b0, 32'd12, 32'd0, 2, 64'd0);

      // annul pulsed in cycle N+10 of 100/7
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      bus.start_i   = 1'b1;
      step();
      repeat (9) step();
      check("annul pre busy", 64'(bus.busy_o), 64'd1);
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      step();
      bus.annul_i = 1'b0;
      check("annul busy", 64'(bus.busy_o), 64'd0);
      check("annul ready", 64'(bus.ready_o), 64'd0);
      check("annul result", bus.result_o, 64'd0);
      seen_ready = 1'b0;
      repeat (40) begin
         step();
         if (bus.ready_o !== 1'b0) seen_ready = 1'b1;
      end
      check("annul no ready", 64'(seen_ready), 64'd0);
      do_div("u9/3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3});

      // annul during divide-by-zero cycle
      bus.opdata1_i = 32'd12;
      bus.opdata2_i = 32'd0;
      bus.start_i   = 1'b1;
      step();
      check("byzero busy", 64'(bus.busy_o), 64'd1);
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      step();
      bus.annul_i = 1'b0;
      check("byzero annul ready", 64'(bus.ready_o), 64'd0);
      check("byzero annul busy", 64'(bus.busy_o), 64'd0);

      // annul in idle blocks start
      bus.opdata1_i = 32'd50;
      bus.opdata2_i = 32'd5;
      bus.start_i   = 1'b1;
      bus.annul_i   = 1'b1;
      step();
      check("idle annul busy", 64'(bus.busy_o), 64'd0);
      step();
      check("idle annul busy2", 64'(bus.busy_o), 64'd0);
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;
      step();

      // reset in cycle N+20 of 100/7
      bus.opdata1_i = 32'd100;
      bus.opdata2_i = 32'd7;
      bus.start_i   = 1'b1;
      step();
      repeat (19) step();
      rst         = 1'b1;
      bus.start_i = 1'b0;
      step();
      rst = 1'b0;
      check("midrst busy", 64'(bus.busy_o), 64'd0);
      check("midrst ready", 64'(bus.ready_o), 64'd0);
      check("midrst result", bus.result_o, 64'd0);
      do_div("post-rst 100/7", 1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
